// File: rtl/dport_pxtimer_pkg.sv
// Shared defaults and helpers for the DisplayPort pixel-timing generator.
package dport_pxtimer_pkg;
  localparam int DP_CNT_W  = 16;
  localparam int DP_FRAC_W = 15;
  localparam int DP_INC_W  = 17;
  localparam int DP_NRATES = 3;

  function automatic int rsel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dport_pxtimer_cfg.sv
// Timing config stage: rate-table mux, shadow bank and load-pending tracking.
// DPORT_PXTIMER_SHADOW_EN selects frame-boundary shadowing; otherwise live pass-through.
module dport_pxtimer_cfg
  import dport_pxtimer_pkg::*;
#(
  parameter int CNT_W  = DP_CNT_W,
  parameter int INC_W  = DP_INC_W,
  parameter int NRATES = DP_NRATES,
  parameter int RSEL_W = rsel_width(NRATES)
) (
  input  logic                    dpclk,
  input  logic                    reset,
  input  logic [RSEL_W-1:0]       rate_sel,
  input  logic [NRATES*INC_W-1:0] sclkinc,
  input  logic [CNT_W-1:0]        htot,
  input  logic [CNT_W-1:0]        vtot,
  input  logic [CNT_W-1:0]        vact,
  input  logic                    cfg_load,
  input  logic                    boundary,
  output logic [CNT_W-1:0]        a_htot,
  output logic [CNT_W-1:0]        a_vtot,
  output logic [CNT_W-1:0]        a_vact,
  output logic [INC_W-1:0]        a_inc,
  output logic                    halted,
  output logic                    load,
  output logic                    cfg_pending
);
  logic [INC_W-1:0] sel_inc;

  // Out-of-range selects fall back to entry 0.
  always_comb begin
    sel_inc = sclkinc[0 +: INC_W];
    for (int k = 1; k < NRATES; k++)
      if (int'(rate_sel) == k) sel_inc = sclkinc[k*INC_W +: INC_W];
  end

`ifdef DPORT_PXTIMER_SHADOW_EN
  logic pend_nxt;

  // A halted generator has no boundary to wait for, so it adopts at once.
  assign load     = halted ? (cfg_load | cfg_pending) : (boundary & cfg_pending);
  assign pend_nxt = !halted && ((cfg_pending && !load) || cfg_load);

  always_ff @(posedge dpclk) begin
    if (reset || load) begin
      a_htot <= htot;
      a_vtot <= vtot;
      a_vact <= vact;
      a_inc  <= sel_inc;
    end
    if (reset) cfg_pending <= 1'b0;
    else       cfg_pending <= pend_nxt;
  end
`else
  logic cfg_unused;

  assign a_htot      = htot;
  assign a_vtot      = vtot;
  assign a_vact      = vact;
  assign a_inc       = sel_inc;
  assign load        = 1'b0;
  assign cfg_pending = 1'b0;
  assign cfg_unused  = ^{dpclk, reset, cfg_load, boundary};
`endif

  assign halted = (a_htot == '0) || (a_inc == '0);
endmodule

// File: rtl/dport_pxtimer.sv
// Fractional pixel-timing generator: accumulator, line counter and strobe registers.
// Shadowed config loading is enabled with DPORT_PXTIMER_SHADOW_EN.
module dport_pxtimer
  import dport_pxtimer_pkg::*;
#(
  parameter int CNT_W  = DP_CNT_W,
  parameter int FRAC_W = DP_FRAC_W,
  parameter int INC_W  = DP_INC_W,
  parameter int NRATES = DP_NRATES,
  parameter int RSEL_W = rsel_width(NRATES)
) (
  input  logic                    dpclk,
  input  logic                    reset,
  input  logic [RSEL_W-1:0]       rate_sel,
  input  logic [NRATES*INC_W-1:0] sclkinc,
  input  logic [CNT_W-1:0]        htot,
  input  logic [CNT_W-1:0]        vtot,
  input  logic [CNT_W-1:0]        vact,
  input  logic                    cfg_load,
  output logic                    dphstart,
  output logic                    dpvstart,
  output logic                    dpvblank,
  output logic                    dpdmahstart,
  output logic                    dmastart,
  output logic [CNT_W-1:0]        line_idx,
  output logic                    cfg_pending
);
  localparam int AW = CNT_W + FRAC_W;

  logic [CNT_W-1:0] a_htot, a_vtot, a_vact;
  logic [INC_W-1:0] a_inc;
  logic             halted, load, line_end, boundary;
  logic [AW-1:0]    acc, acc_step;
  logic [CNT_W-1:0] yctr;

  dport_pxtimer_cfg #(
    .CNT_W (CNT_W),
    .INC_W (INC_W),
    .NRATES(NRATES),
    .RSEL_W(RSEL_W)
  ) u_cfg (
    .dpclk      (dpclk),
    .reset      (reset),
    .rate_sel   (rate_sel),
    .sclkinc    (sclkinc),
    .htot       (htot),
    .vtot       (vtot),
    .vact       (vact),
    .cfg_load   (cfg_load),
    .boundary   (boundary),
    .a_htot     (a_htot),
    .a_vtot     (a_vtot),
    .a_vact     (a_vact),
    .a_inc      (a_inc),
    .halted     (halted),
    .load       (load),
    .cfg_pending(cfg_pending)
  );

  assign line_end = !halted && (acc[AW-1:FRAC_W] >= a_htot);
  assign boundary = line_end && (yctr == a_vtot);
  // Carrying the remainder past the line end keeps long-term timing drift-free.
  assign acc_step = line_end ? (acc - {a_htot, {FRAC_W{1'b0}}} + AW'(a_inc))
                             : (acc + AW'(a_inc));

  always_ff @(posedge dpclk) begin
    if (reset) begin
      acc         <= '0;
      yctr        <= '0;
      line_idx    <= '0;
      dphstart    <= 1'b0;
      dpvstart    <= 1'b0;
      dpvblank    <= 1'b0;
      dpdmahstart <= 1'b0;
      dmastart    <= 1'b0;
    end else begin
      dphstart    <= line_end;
      dpvstart    <= line_end && (yctr == '0);
      dpdmahstart <= line_end && (yctr < a_vact);
      dpvblank    <= line_end && (yctr == a_vact);
      dmastart    <= boundary;
      if (line_end) begin
        line_idx <= yctr;
        yctr     <= boundary ? '0 : yctr + 1'b1;
      end
      if (load)         acc <= '0;
      else if (!halted) acc <= acc_step;
    end
  end
endmodule

// File: tb/tb_dport_pxtimer.sv
// Bench for dport_pxtimer: directed timing checks plus randomized runs against a cycle model.
module tb_dport_pxtimer;
  localparam int CNT_W  = 16;
  localparam int FRAC_W = 15;
  localparam int INC_W  = 17;
  localparam int NRATES = 3;
  localparam int RSEL_W = 2;
  localparam int AW     = CNT_W + FRAC_W;
  localparam longint AMASK = (64'd1 << AW) - 1;
`ifdef DPORT_PXTIMER_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                    dpclk = 1'b0;
  logic                    reset;
  logic [RSEL_W-1:0]       rate_sel;
  logic [NRATES*INC_W-1:0] sclkinc;
  logic [CNT_W-1:0]        htot, vtot, vact;
  logic                    cfg_load;
  logic                    dphstart, dpvstart, dpvblank, dpdmahstart, dmastart, cfg_pending;
  logic [CNT_W-1:0]        line_idx;

  dport_pxtimer #(
    .CNT_W(CNT_W), .FRAC_W(FRAC_W), .INC_W(INC_W), .NRATES(NRATES), .RSEL_W(RSEL_W)
  ) dut (
    .dpclk(dpclk), .reset(reset), .rate_sel(rate_sel), .sclkinc(sclkinc),
    .htot(htot), .vtot(vtot), .vact(vact), .cfg_load(cfg_load),
    .dphstart(dphstart), .dpvstart(dpvstart), .dpvblank(dpvblank),
    .dpdmahstart(dpdmahstart), .dmastart(dmastart), .line_idx(line_idx),
    .cfg_pending(cfg_pending)
  );

  always #5 dpclk = ~dpclk;

  int checks = 0;
  int errors = 0;

  logic [CNT_W+5:0] obs, exp_v;
  assign obs = {dphstart, dpvstart, dpvblank, dpdmahstart, dmastart, cfg_pending, line_idx};

  // Reference model state: pixel position in 1/2^FRAC_W pixel units, current line.
  longint m_acc;
  int     m_y;
  int     e_li;
  bit     e_hs, e_vs, e_vb, e_dh, e_dm, e_pend;
`ifdef DPORT_PXTIMER_SHADOW_EN
  int     m_htot, m_vtot, m_vact, m_inc;
  bit     m_pend;
`endif

  function automatic int tbl_inc();
    int k;
    k = (int'(rate_sel) < NRATES) ? int'(rate_sel) : 0;
    return int'(sclkinc[k*INC_W +: INC_W]);
  endfunction

  task automatic model_step();
    int h, v, a, inc;
    bit halted, le, bnd;
    if (reset) begin
      m_acc = 0; m_y = 0; e_li = 0;
      {e_hs, e_vs, e_vb, e_dh, e_dm, e_pend} = '0;
`ifdef DPORT_PXTIMER_SHADOW_EN
      m_pend = 0;
      m_htot = int'(htot); m_vtot = int'(vtot); m_vact = int'(vact); m_inc = tbl_inc();
`endif
    end else begin
`ifdef DPORT_PXTIMER_SHADOW_EN
      h = m_htot; v = m_vtot; a = m_vact; inc = m_inc;
`else
      h = int'(htot); v = int'(vtot); a = int'(vact); inc = tbl_inc();
`endif
      halted = (h == 0) || (inc == 0);
      le  = !halted && ((m_acc >> FRAC_W) >= longint'(h));
      bnd = le && (m_y == v);
      e_hs = le;
      e_vs = le && (m_y == 0);
      e_dh = le && (m_y < a);
      e_vb = le && (m_y == a);
      e_dm = bnd;
      if (le) begin
        e_li  = m_y;
        m_acc = m_acc - (longint'(h) << FRAC_W) + longint'(inc);
        m_y   = bnd ? 0 : (m_y + 1) % (1 << CNT_W);
      end else if (!halted) begin
        m_acc = m_acc + longint'(inc);
      end
      m_acc = m_acc & AMASK;
`ifdef DPORT_PXTIMER_SHADOW_EN
      begin
        bit ld;
        ld = halted ? (cfg_load || m_pend) : (bnd && m_pend);
        m_pend = !halted && ((m_pend && !ld) || cfg_load);
        if (ld) begin
          m_acc = 0;
          m_htot = int'(htot); m_vtot = int'(vtot); m_vact = int'(vact); m_inc = tbl_inc();
        end
      end
      e_pend = m_pend;
`else
      e_pend = 1'b0;
`endif
    end
    exp_v = {e_hs, e_vs, e_vb, e_dh, e_dm, e_pend, CNT_W'(e_li)};
  endtask

  task automatic chk(input string tag, input longint o, input longint e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge dpclk);
    #1;
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL model observed=%h expected=%h", obs, exp_v);
    end
  endtask

  // Cycles until the next dphstart, bounded by max (a timeout shows up as n==max).
  task automatic wait_hs(input int max, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!dphstart && n < max);
  endtask

  task automatic set_tbl(input int e0, input int e1, input int e2);
    sclkinc[0*INC_W +: INC_W] = INC_W'(e0);
    sclkinc[1*INC_W +: INC_W] = INC_W'(e1);
    sclkinc[2*INC_W +: INC_W] = INC_W'(e2);
  endtask

  task automatic rst();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int n, tot, cnt;
    reset = 1'b1; cfg_load = 1'b0; rate_sel = '0;
    htot = 4; vtot = 2; vact = 1;
    set_tbl(32768, 16384, 65536);
    cyc(); cyc();
    chk("reset_outputs", obs, 0);

    // Integer increment, 3-line frame
    reset = 1'b0;
    wait_hs(40, n);
    chk("first_hs_latency", n, 5);
    chk("first_vstart", dpvstart, 1);
    chk("line0_idx", line_idx, 0);
    chk("line0_dmah", dpdmahstart, 1);
    wait_hs(40, n);
    chk("int_period", n, 4);
    chk("line1_idx", line_idx, 1);
    chk("line1_vblank", dpvblank, 1);
    chk("line1_dmah", dpdmahstart, 0);
    wait_hs(40, n);
    chk("line2_idx", line_idx, 2);
    chk("line2_dmastart", dmastart, 1);
    wait_hs(40, n);
    chk("wrap_idx", line_idx, 0);
    chk("wrap_vstart", dpvstart, 1);

    // Fractional 0.75 increment: 100 lines in exactly 400 cycles
    htot = 3; set_tbl(24576, 16384, 65536);
    rst();
    wait_hs(40, n);
    chk("frac_first_latency", n, 5);
    tot = 0;
    for (int i = 0; i < 100; i++) begin
      wait_hs(40, n);
      tot += n;
    end
    chk("frac_100_lines", tot, 400);

    // inc=20000, htot=3: 12288 cycles hold 2500 lines, +-1
    set_tbl(20000, 16384, 65536);
    rst();
    cnt = 0;
    for (int i = 0; i < 12288; i++) begin
      cyc();
      if (dphstart) cnt++;
    end
    chk("frac_line_count", (cnt >= 2499 && cnt <= 2501), 1);

    // Rate select
    htot = 4; set_tbl(32768, 16384, 65536);
    rate_sel = 1;
    rst();
    wait_hs(40, n);
    wait_hs(40, n);
    chk("rate1_period", n, 8);
    rate_sel = 3;
    rst();
    wait_hs(40, n);
    wait_hs(40, n);
    chk("rate_oob_period", n, 4);
    rate_sel = 0;

    // Halt with zero increment, then adopt 1.0
    set_tbl(0, 16384, 65536);
    rst();
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (dphstart || dpvstart || dpvblank || dpdmahstart || dmastart) cnt++;
    end
    chk("halt_no_strobes", cnt, 0);
    set_tbl(32768, 16384, 65536);
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    wait_hs(40, n);
    chk("halt_release_latency", n + 1, SHADOW ? 6 : 5);
    chk("halt_release_vstart", dpvstart, 1);

    // Config change mid-frame
    rst();
    wait_hs(40, n);
    cyc();
    htot = 8; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    chk("pending_set", cfg_pending, SHADOW);
`ifdef DPORT_PXTIMER_SHADOW_EN
    wait_hs(40, n);
    chk("shadow_old_period1", n, 4);
    wait_hs(40, n);
    chk("shadow_old_period2", n, 4);
    chk("shadow_dmastart", dmastart, 1);
    chk("shadow_pending_clr", cfg_pending, 0);
    wait_hs(40, n);
    chk("shadow_new_vstart", dpvstart, 1);
    wait_hs(40, n);
    chk("shadow_new_period", n, 8);
`else
    wait_hs(40, n);
    wait_hs(40, n);
    chk("live_new_period", n, 8);
`endif

    // Reset mid-line with a pending load
    htot = 4;
    rst();
    wait_hs(40, n);
    cyc();
    htot = 6; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    chk("pending_before_reset", cfg_pending, SHADOW);
    reset = 1'b1;
    cyc();
    chk("reset_mid_outputs", obs, 0);
    reset = 1'b0;
    wait_hs(40, n);
    chk("reset_restart_latency", n, 7);
    chk("reset_restart_idx", line_idx, 0);
    chk("reset_restart_vstart", dpvstart, 1);

    // Randomized configs and mid-run perturbations
    for (int it = 0; it < 12; it++) begin
      htot = CNT_W'($urandom_range(0, 12));
      vtot = CNT_W'($urandom_range(0, 4));
      vact = CNT_W'($urandom_range(0, 6));
      rate_sel = RSEL_W'($urandom_range(0, 3));
      set_tbl($urandom_range(0, 131071), $urandom_range(1, 65536), $urandom_range(4096, 40000));
      rst();
      for (int c = 0; c < 300; c++) begin
        cfg_load = ($urandom_range(0, 39) == 0);
        if (cfg_load || $urandom_range(0, 59) == 0) begin
          case ($urandom_range(0, 4))
            0: htot = CNT_W'($urandom_range(0, 12));
            1: vtot = CNT_W'($urandom_range(0, 4));
            2: vact = CNT_W'($urandom_range(0, 6));
            3: rate_sel = RSEL_W'($urandom_range(0, 3));
            default: set_tbl($urandom_range(0, 131071), $urandom_range(1, 65536),
                             $urandom_range(4096, 40000));
          endcase
        end
        cyc();
      end
      cfg_load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
